// File: rtl/axi4_slave_write_arbiter.sv
// Write-path arbiter for one crossbar slave port: round-robin AW grant with ID widening,
// W beats routed in AW-grant order via a small order FIFO, and B responses steered back by BID.
module axi4_slave_write_arbiter #(
  parameter int MASTER_NUM   = 4,
  parameter int W_ID_LEN     = 4,
  parameter int EXTRA_ID_LEN = $clog2(MASTER_NUM),
  parameter int AW_PAYLOAD_W = 54,
  parameter int DATA_WIDTH   = 64,
  parameter int W_BUF_DEPTH  = 2
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETn,
  input  logic [MASTER_NUM-1:0]                m_awvalid,
  input  logic [MASTER_NUM*W_ID_LEN-1:0]       m_awid,
  input  logic [MASTER_NUM*AW_PAYLOAD_W-1:0]   m_awpayload,
  output logic [MASTER_NUM-1:0]                m_awready,
  input  logic [MASTER_NUM-1:0]                m_wvalid,
  input  logic [MASTER_NUM-1:0]                m_wlast,
  input  logic [MASTER_NUM*DATA_WIDTH-1:0]     m_wdata,
  input  logic [MASTER_NUM*DATA_WIDTH/8-1:0]   m_wstrb,
  output logic [MASTER_NUM-1:0]                m_wready,
  output logic [MASTER_NUM-1:0]                m_bvalid,
  output logic [W_ID_LEN-1:0]                  m_bid,
  output logic [1:0]                           m_bresp,
  input  logic [MASTER_NUM-1:0]                m_bready,
  output logic                                 s_awvalid,
  input  logic                                 s_awready,
  output logic [EXTRA_ID_LEN+W_ID_LEN-1:0]     s_awid,
  output logic [AW_PAYLOAD_W-1:0]              s_awpayload,
  output logic                                 s_wvalid,
  output logic                                 s_wlast,
  output logic [DATA_WIDTH-1:0]                s_wdata,
  output logic [DATA_WIDTH/8-1:0]              s_wstrb,
  input  logic                                 s_wready,
  input  logic                                 s_bvalid,
  input  logic [EXTRA_ID_LEN+W_ID_LEN-1:0]     s_bid,
  input  logic [1:0]                           s_bresp,
  output logic                                 s_bready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (W_BUF_DEPTH > 1) ? $clog2(W_BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(W_BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(W_BUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(W_BUF_DEPTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]              state;
  logic [EXTRA_ID_LEN-1:0] last_grant;
  logic [EXTRA_ID_LEN-1:0] grant_idx;
  logic                    req_found;
  logic                    do_grant;
  logic [W_ID_LEN-1:0]     sel_awid;
  logic [AW_PAYLOAD_W-1:0] sel_payload;

  logic [EXTRA_ID_LEN-1:0] fifo_mem [W_BUF_DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        count;
  logic [EXTRA_ID_LEN-1:0] head;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic [EXTRA_ID_LEN-1:0] bidx;

  // Round-robin scan starting just after last_grant; both loops unroll to constant indices.
  always_comb begin
    req_found = 1'b0;
    grant_idx = last_grant;
    for (int off = 1; off <= MASTER_NUM; off++) begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (!req_found && last_grant == EXTRA_ID_LEN'(i) && m_awvalid[(i + off) % MASTER_NUM]) begin
          req_found = 1'b1;
          grant_idx = EXTRA_ID_LEN'((i + off) % MASTER_NUM);
        end
      end
    end
  end

  // Full check deliberately uses the registered count, so a same-cycle pop cannot free a slot.
  assign do_grant = (state == IDLE) && req_found && (count < DEPTH_C);
  assign push     = do_grant;
  assign s_awvalid = (state == HOLD);

  always_comb begin
    sel_awid    = '0;
    sel_payload = '0;
    m_awready   = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (grant_idx == EXTRA_ID_LEN'(i)) begin
        sel_awid     = m_awid[i*W_ID_LEN +: W_ID_LEN];
        sel_payload  = m_awpayload[i*AW_PAYLOAD_W +: AW_PAYLOAD_W];
        m_awready[i] = do_grant;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= IDLE;
      last_grant  <= EXTRA_ID_LEN'(MASTER_NUM - 1);
      s_awid      <= '0;
      s_awpayload <= '0;
    end else if (state == IDLE) begin
      if (do_grant) begin
        state       <= HOLD;
        last_grant  <= grant_idx;
        s_awid      <= {grant_idx, sel_awid};
        s_awpayload <= sel_payload;
      end
    end else if (s_awready) begin
      state <= IDLE;
    end
  end

  // W channel follows the oldest granted master still owing its burst.
  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign pop        = s_wvalid & s_wready & s_wlast;

  always_comb begin
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m_wready = '0;
    if (!fifo_empty) begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        if (head == EXTRA_ID_LEN'(i)) begin
          s_wvalid    = m_wvalid[i];
          s_wlast     = m_wlast[i];
          s_wdata     = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
          s_wstrb     = m_wstrb[i*STRB_W +: STRB_W];
          m_wready[i] = s_wready;
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < W_BUF_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= grant_idx;
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  // An index with no matching master leaves s_bready high so the response is sunk.
  assign bidx    = s_bid[EXTRA_ID_LEN+W_ID_LEN-1 -: EXTRA_ID_LEN];
  assign m_bid   = s_bid[W_ID_LEN-1:0];
  assign m_bresp = s_bresp;

  always_comb begin
    m_bvalid = '0;
    s_bready = 1'b1;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (bidx == EXTRA_ID_LEN'(i)) begin
        m_bvalid[i] = s_bvalid;
        s_bready    = m_bready[i];
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_write_arbiter.sv
// Directed bench for axi4_slave_write_arbiter: reset, AW grant/hold, round-robin order,
// W ordering, FIFO-full backpressure, B routing and mid-burst reset.
module tb_axi4_slave_write_arbiter;

  logic         ACLK;
  logic         ARESETn;
  logic [3:0]   m_awvalid;
  logic [15:0]  m_awid;
  logic [215:0] m_awpayload;
  logic [3:0]   m_awready;
  logic [3:0]   m_wvalid;
  logic [3:0]   m_wlast;
  logic [255:0] m_wdata;
  logic [31:0]  m_wstrb;
  logic [3:0]   m_wready;
  logic [3:0]   m_bvalid;
  logic [3:0]   m_bid;
  logic [1:0]   m_bresp;
  logic [3:0]   m_bready;
  logic         s_awvalid;
  logic         s_awready;
  logic [5:0]   s_awid;
  logic [53:0]  s_awpayload;
  logic         s_wvalid;
  logic         s_wlast;
  logic [63:0]  s_wdata;
  logic [7:0]   s_wstrb;
  logic         s_wready;
  logic         s_bvalid;
  logic [5:0]   s_bid;
  logic [1:0]   s_bresp;
  logic         s_bready;

  int vectors;
  int miscompares;

  axi4_slave_write_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awpayload(m_awpayload), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bid(m_bid), .m_bresp(m_bresp), .m_bready(m_bready),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awpayload(s_awpayload),
    .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp), .s_bready(s_bready)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [53:0] mk_payload(input logic [31:0] addr);
    return {addr, 8'd0, 3'd3, 2'd1, 2'd0, 4'd0, 3'd0};
  endfunction

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    m_awvalid = '0; m_awid = '0; m_awpayload = '0;
    m_wvalid = '0; m_wlast = '0; m_wdata = '0; m_wstrb = '0;
    m_bready = '0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ARESETn = 1'b0;
    cyc();
    cyc();
    ARESETn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    ARESETn = 1'b0;
    #2;
    vectors++;
    if (s_awvalid !== 1'b0 || s_awid !== 6'h00 || s_awpayload !== 54'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_aw: got valid=%b id=%h payload=%h, required 0/00/0", s_awvalid, s_awid, s_awpayload);
    end
    vectors++;
    if (m_awready !== 4'b0 || m_wready !== 4'b0 || s_wvalid !== 1'b0 || m_bvalid !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_comb: got awready=%b wready=%b swvalid=%b bvalid=%b, required zeros", m_awready, m_wready, s_wvalid, m_bvalid);
    end
    cyc();
    ARESETn = 1'b1;
  endtask

  task automatic test_single_aw();
    do_reset();
    m_awvalid = 4'b0100;
    m_awid[2*4 +: 4] = 4'h5;
    m_awpayload[2*54 +: 54] = mk_payload(32'h100);
    #1;
    vectors++;
    if (m_awready !== 4'b0100 || s_awvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_grant: got awready=%b awvalid=%b, required 0100/0", m_awready, s_awvalid);
    end
    cyc();
    m_awvalid = 4'b0;
    #1;
    vectors++;
    if (s_awvalid !== 1'b1 || s_awid !== 6'h25 || s_awpayload !== mk_payload(32'h100) || m_awready !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL single_hold: got valid=%b id=%h payload=%h awready=%b, required 1/25/%h/0000", s_awvalid, s_awid, s_awpayload, m_awready, mk_payload(32'h100));
    end
    cyc();
    vectors++;
    if (s_awvalid !== 1'b1 || s_awid !== 6'h25) begin
      miscompares++;
      $display("[TB] FAIL single_stable: got valid=%b id=%h, required 1/25", s_awvalid, s_awid);
    end
    s_awready = 1'b1;
    cyc();
    s_awready = 1'b0;
    #1;
    vectors++;
    if (s_awvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_release: got awvalid=%b, required 0", s_awvalid);
    end
    m_wvalid = 4'b0100; m_wlast = 4'b0100; s_wready = 1'b1;
    m_wdata[2*64 +: 64] = 64'hDEAD_BEEF_0000_0002;
    m_wstrb[2*8 +: 8] = 8'hF0;
    #1;
    vectors++;
    if (s_wvalid !== 1'b1 || s_wdata !== 64'hDEAD_BEEF_0000_0002 || s_wstrb !== 8'hF0 || m_wready !== 4'b0100) begin
      miscompares++;
      $display("[TB] FAIL single_w: got valid=%b data=%h strb=%h wready=%b, required 1/deadbeef00000002/f0/0100", s_wvalid, s_wdata, s_wstrb, m_wready);
    end
    cyc();
    clear_inputs();
    #1;
    vectors++;
    if (m_wready !== 4'b0 || s_wvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_pop: got wready=%b swvalid=%b, required 0000/0", m_wready, s_wvalid);
    end
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [5:0] exp_id;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_awid[i*4 +: 4] = 4'(8 + i);
      m_wdata[i*64 +: 64] = 64'h1000 + 64'(i);
    end
    m_awvalid = 4'b1111; m_wvalid = 4'b1111; m_wlast = 4'b1111;
    s_awready = 1'b1; s_wready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_id = {2'(seq[k]), 4'(8 + seq[k])};
      #1;
      vectors++;
      if (m_awready !== (4'b0001 << seq[k]) || s_awvalid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rr_grant%0d: got awready=%b awvalid=%b, required %b/0", k, m_awready, s_awvalid, 4'b0001 << seq[k]);
      end
      cyc();
      vectors++;
      if (s_awvalid !== 1'b1 || s_awid !== exp_id || m_wready !== (4'b0001 << seq[k]) || s_wdata !== 64'h1000 + 64'(seq[k])) begin
        miscompares++;
        $display("[TB] FAIL rr_issue%0d: got awvalid=%b id=%h wready=%b data=%h, required 1/%h/%b", k, s_awvalid, s_awid, m_wready, s_wdata, exp_id, 4'b0001 << seq[k]);
      end
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_w_order();
    do_reset();
    s_awready = 1'b1;
    m_awvalid = 4'b0010;
    cyc();
    m_awvalid = 4'b0;
    cyc();
    m_awvalid = 4'b1000;
    #1;
    vectors++;
    if (m_awready !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL order_grant3: got awready=%b, required 1000", m_awready);
    end
    cyc();
    m_awvalid = 4'b0;
    cyc();
    s_awready = 1'b0;
    m_wvalid = 4'b1010; m_wlast = 4'b1000; s_wready = 1'b1;
    m_wdata[3*64 +: 64] = 64'h3333;
    for (int b = 0; b < 4; b++) begin
      m_wdata[1*64 +: 64] = 64'h1100 + 64'(b);
      m_wlast[1] = (b == 3);
      #1;
      vectors++;
      if (m_wready !== 4'b0010 || s_wdata !== 64'h1100 + 64'(b) || s_wlast !== (b == 3)) begin
        miscompares++;
        $display("[TB] FAIL order_m1_beat%0d: got wready=%b data=%h last=%b, required 0010/%h/%b", b, m_wready, s_wdata, s_wlast, 64'h1100 + 64'(b), b == 3);
      end
      cyc();
    end
    m_wvalid[1] = 1'b0; m_wlast[1] = 1'b0;
    #1;
    vectors++;
    if (m_wready !== 4'b1000 || s_wdata !== 64'h3333 || s_wlast !== 1'b1 || s_wvalid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL order_m3: got wready=%b data=%h last=%b valid=%b, required 1000/3333/1/1", m_wready, s_wdata, s_wlast, s_wvalid);
    end
    cyc();
    #1;
    vectors++;
    if (m_wready !== 4'b0 || s_wvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL order_empty: got wready=%b swvalid=%b, required 0000/0", m_wready, s_wvalid);
    end
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    s_awready = 1'b1;
    m_awvalid = 4'b0010;
    cyc();
    m_awvalid = 4'b0;
    cyc();
    m_awvalid = 4'b0100;
    cyc();
    m_awvalid = 4'b0;
    cyc();
    s_awready = 1'b0;
    m_awid[0 +: 4] = 4'h3;
    m_awvalid = 4'b0001;
    #1;
    vectors++;
    if (m_awready !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL full_block0: got awready=%b, required 0000", m_awready);
    end
    cyc();
    vectors++;
    if (m_awready !== 4'b0 || s_awvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL full_block1: got awready=%b awvalid=%b, required 0000/0", m_awready, s_awvalid);
    end
    m_wvalid = 4'b0010; m_wlast = 4'b0010; s_wready = 1'b1;
    #1;
    vectors++;
    if (m_awready !== 4'b0 || m_wready !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL full_popcycle: got awready=%b wready=%b, required 0000/0010", m_awready, m_wready);
    end
    cyc();
    m_wvalid = 4'b0; m_wlast = 4'b0;
    #1;
    vectors++;
    if (m_awready !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL full_grant: got awready=%b, required 0001", m_awready);
    end
    cyc();
    m_awvalid = 4'b0;
    #1;
    vectors++;
    if (s_awvalid !== 1'b1 || s_awid !== 6'h03) begin
      miscompares++;
      $display("[TB] FAIL full_issue: got awvalid=%b id=%h, required 1/03", s_awvalid, s_awid);
    end
    clear_inputs();
  endtask

  task automatic test_b_routing();
    clear_inputs();
    s_bvalid = 1'b1; s_bid = 6'h3A; s_bresp = 2'b10; m_bready = 4'b0;
    #1;
    vectors++;
    if (m_bvalid !== 4'b1000 || m_bid !== 4'hA || m_bresp !== 2'b10 || s_bready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b_route3: got bvalid=%b bid=%h bresp=%b bready=%b, required 1000/a/10/0", m_bvalid, m_bid, m_bresp, s_bready);
    end
    m_bready = 4'b1000;
    #1;
    vectors++;
    if (s_bready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b_ready3: got s_bready=%b, required 1", s_bready);
    end
    m_bready = 4'b0111;
    #1;
    vectors++;
    if (s_bready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b_ready_other: got s_bready=%b, required 0", s_bready);
    end
    s_bid = 6'h17; s_bresp = 2'b00;
    #1;
    vectors++;
    if (m_bvalid !== 4'b0010 || m_bid !== 4'h7 || s_bready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b_route1: got bvalid=%b bid=%h bready=%b, required 0010/7/1", m_bvalid, m_bid, s_bready);
    end
    s_bvalid = 1'b0;
    #1;
    vectors++;
    if (m_bvalid !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL b_idle: got bvalid=%b, required 0000", m_bvalid);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    m_awvalid = 4'b0010;
    m_awid[1*4 +: 4] = 4'h6;
    cyc();
    m_awvalid = 4'b0;
    m_wvalid = 4'b0010; m_wlast = 4'b0; s_wready = 1'b1;
    #1;
    vectors++;
    if (m_wready !== 4'b0010 || s_awvalid !== 1'b1 || s_awid !== 6'h16) begin
      miscompares++;
      $display("[TB] FAIL midrst_pre: got wready=%b awvalid=%b id=%h, required 0010/1/16", m_wready, s_awvalid, s_awid);
    end
    cyc();
    cyc();
    ARESETn = 1'b0;
    #1;
    vectors++;
    if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0 || m_wready !== 4'b0 || s_awid !== 6'h00) begin
      miscompares++;
      $display("[TB] FAIL midrst_clear: got awvalid=%b swvalid=%b wready=%b id=%h, required 0/0/0000/00", s_awvalid, s_wvalid, m_wready, s_awid);
    end
    cyc();
    ARESETn = 1'b1;
    m_wvalid = 4'b0;
    m_awvalid = 4'b1111;
    #1;
    vectors++;
    if (m_awready !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL midrst_regrant: got awready=%b, required 0001", m_awready);
    end
    cyc();
    clear_inputs();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    ARESETn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_aw();
    test_round_robin();
    test_w_order();
    test_fifo_full();
    test_b_routing();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
